alu_arbiter: RTL and testbench

Shares the single combinational `alu` datapath between two requesters: port 0 is the EX-stage pipeline, port 1 is the CP0/exception address-calculation path. It accepts one operation at a time over a req/ack handshake and latches the operands. It then evaluates them in the owned `alu` instance and returns a registered result with a one-cycle ack pulse. Round-robin arbitration resolves simultaneous requests.

---
 rtl/alu_arbiter_pkg.sv | 31 +++
 rtl/alu_arbiter_alu.sv | 51 +++++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings, opcode width and arbiter FSM state type.
package alu_arbiter_pkg;

  localparam int unsigned ALU_OPT_WIDTH = 4;

  typedef logic [ALU_OPT_WIDTH-1:0] alu_opt_t;

  localparam alu_opt_t OptAddu   = 4'd0;
  localparam alu_opt_t OptSubu   = 4'd1;
  localparam alu_opt_t OptAnd    = 4'd2;
  localparam alu_opt_t OptOr     = 4'd3;
  localparam alu_opt_t OptXor    = 4'd4;
  localparam alu_opt_t OptNor    = 4'd5;
  localparam alu_opt_t OptSlt    = 4'd6;
  localparam alu_opt_t OptSltu   = 4'd7;
  localparam alu_opt_t OptSll    = 4'd8;
  localparam alu_opt_t OptSrl    = 4'd9;
  localparam alu_opt_t OptSra    = 4'd10;
  localparam alu_opt_t OptSllImm = 4'd11;
  localparam alu_opt_t OptSrlImm = 4'd12;
  localparam alu_opt_t OptSraImm = 4'd13;
  // Address calculation: opr1 + sa_imm. Encoding 15 is unused and therefore illegal.
  localparam alu_opt_t OptAddImm = 4'd14;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU datapath; unknown opcodes give result 0 with illegal_opt_o set.
module alu_arbiter_alu import alu_arbiter_pkg::*; #(
  parameter int unsigned OptW = ALU_OPT_WIDTH
) (
  input  logic [31:0]   opr1_i,
  input  logic [31:0]   opr2_i,
  input  logic [31:0]   sa_imm_i,
  input  logic [OptW-1:0] opt_i,
  output logic [31:0]   result_o,
  output logic          illegal_opt_o
);

  alu_opt_t   op;
  logic       hi_zero;
  logic [4:0] sh_var;
  logic [4:0] sh_imm;

  // OptW wider than the opcode table: any set upper bit is an unused encoding
  assign op      = opt_i[ALU_OPT_WIDTH-1:0];
  assign hi_zero = (opt_i >> ALU_OPT_WIDTH) == '0;
  assign sh_var  = opr1_i[4:0];
  assign sh_imm  = sa_imm_i[4:0];

  always_comb begin
    result_o      = '0;
    illegal_opt_o = 1'b0;
    if (!hi_zero) begin
      illegal_opt_o = 1'b1;
    end else begin
      case (op)
        OptAddu:   result_o = opr1_i + opr2_i;
        OptSubu:   result_o = opr1_i - opr2_i;
        OptAnd:    result_o = opr1_i & opr2_i;
        OptOr:     result_o = opr1_i | opr2_i;
        OptXor:    result_o = opr1_i ^ opr2_i;
        OptNor:    result_o = ~(opr1_i | opr2_i);
        OptSlt:    result_o = {31'b0, $signed(opr1_i) < $signed(opr2_i)};
        OptSltu:   result_o = {31'b0, opr1_i < opr2_i};
        OptSll:    result_o = opr2_i << sh_var;
        OptSrl:    result_o = opr2_i >> sh_var;
        OptSra:    result_o = 32'($signed(opr2_i) >>> sh_var);
        OptSllImm: result_o = opr2_i << sh_imm;
        OptSrlImm: result_o = opr2_i >> sh_imm;
        OptSraImm: result_o = 32'($signed(opr2_i) >>> sh_imm);
        OptAddImm: result_o = opr1_i + sa_imm_i;
        default:   illegal_opt_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port req/ack arbiter sharing one ALU; round-robin on ties unless
// ALU_ARB_FIXED_PRIO_EN is defined, which makes port 0 always win a tie.
module alu_arbiter import alu_arbiter_pkg::*; #(
  parameter int unsigned OptW = ALU_OPT_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic [31:0]     opr1_0_i,
  input  logic [31:0]     opr2_0_i,
  input  logic [31:0]     sa_imm_0_i,
  input  logic [OptW-1:0] opt_0_i,
  input  logic [31:0]     opr1_1_i,
  input  logic [31:0]     opr2_1_i,
  input  logic [31:0]     sa_imm_1_i,
  input  logic [OptW-1:0] opt_1_i,
  output logic            ack0_o,
  output logic            ack1_o,
  output logic [31:0]     result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  arb_state_e      state_q, state_d;
  logic [31:0]     opr1_q, opr1_d, opr2_q, opr2_d, sa_imm_q, sa_imm_d;
  logic [OptW-1:0] opt_q, opt_d;
  logic            gnt_id_q, gnt_id_d;
  logic [31:0]     result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            win;
  logic [31:0]     alu_result;
  logic            alu_illegal;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = ~req0_i;
`else
  logic last_gnt_q, last_gnt_d;

  // On a tie the port that did not win last time goes next
  assign win = (req0_i && req1_i) ? ~last_gnt_q : req1_i;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == StIdle && (req0_i || req1_i)) last_gnt_d = win;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_gnt_q <= 1'b1;
    else       last_gnt_q <= last_gnt_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    opr1_d    = opr1_q;
    opr2_d    = opr2_q;
    sa_imm_d  = sa_imm_q;
    opt_d     = opt_q;
    gnt_id_d  = gnt_id_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          state_d  = StExec;
          gnt_id_d = win;
          opr1_d   = win ? opr1_1_i   : opr1_0_i;
          opr2_d   = win ? opr2_1_i   : opr2_0_i;
          sa_imm_d = win ? sa_imm_1_i : sa_imm_0_i;
          opt_d    = win ? opt_1_i    : opt_0_i;
        end
      end
      StExec: begin
        state_d   = StResp;
        result_d  = alu_result;
        illegal_d = alu_illegal;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      opr1_q    <= '0;
      opr2_q    <= '0;
      sa_imm_q  <= '0;
      opt_q     <= '0;
      gnt_id_q  <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opr1_q    <= opr1_d;
      opr2_q    <= opr2_d;
      sa_imm_q  <= sa_imm_d;
      opt_q     <= opt_d;
      gnt_id_q  <= gnt_id_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  alu_arbiter_alu #(
    .OptW (OptW)
  ) u_alu (
    .opr1_i        (opr1_q),
    .opr2_i        (opr2_q),
    .sa_imm_i      (sa_imm_q),
    .opt_i         (opt_q),
    .result_o      (alu_result),
    .illegal_opt_o (alu_illegal)
  );

  assign ack0_o    = (state_q == StResp) && !gnt_id_q;
  assign ack1_o    = (state_q == StResp) && gnt_id_q;
  assign result_o  = result_q;
  assign illegal_o = illegal_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts each grant
// and its ALU result; a monitor checks every ack against the predicted queue.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned OptW = ALU_OPT_WIDTH;
  localparam int Timeout = 300;

  typedef struct {
    int          port;
    int          due;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req  [2];
  logic [31:0]     opr1 [2];
  logic [31:0]     opr2 [2];
  logic [31:0]     sa   [2];
  logic [OptW-1:0] opt  [2];
  logic            ack0, ack1, illegal, busy;
  logic [31:0]     result;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .OptW (OptW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req0_i     (req[0]),
    .req1_i     (req[1]),
    .opr1_0_i   (opr1[0]),
    .opr2_0_i   (opr2[0]),
    .sa_imm_0_i (sa[0]),
    .opt_0_i    (opt[0]),
    .opr1_1_i   (opr1[1]),
    .opr2_1_i   (opr2[1]),
    .sa_imm_1_i (sa[1]),
    .opt_1_i    (opt[1]),
    .ack0_o     (ack0),
    .ack1_o     (ack1),
    .result_o   (result),
    .illegal_o  (illegal),
    .busy_o     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Reference ALU written as plain arithmetic; returns {illegal, result}
  function automatic logic [32:0] ref_alu(input logic [OptW-1:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] s);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sb_v = longint'($signed(b));
    longint unsigned pa = 64'd1 << (a % 32);
    longint unsigned ps = 64'd1 << (s % 32);
    case (op)
      OptAddu:   return {1'b0, 32'(ua + ub)};
      OptSubu:   return {1'b0, 32'(ua + 64'h1_0000_0000 - ub)};
      OptAnd:    return {1'b0, a & b};
      OptOr:     return {1'b0, a | b};
      OptXor:    return {1'b0, a ^ b};
      OptNor:    return {1'b0, ~(a | b)};
      OptSlt:    return {1'b0, 32'(longint'($signed(a)) < sb_v)};
      OptSltu:   return {1'b0, 32'(ua < ub)};
      OptSll:    return {1'b0, 32'(ub * pa)};
      OptSrl:    return {1'b0, 32'(ub / pa)};
      OptSra:    return {1'b0, 32'(sb_v >>> (a % 32))};
      OptSllImm: return {1'b0, 32'(ub * ps)};
      OptSrlImm: return {1'b0, 32'(ub / ps)};
      OptSraImm: return {1'b0, 32'(sb_v >>> (s % 32))};
      OptAddImm: return {1'b0, 32'(ua + longint'(s))};
      default:   return {1'b1, 32'd0};
    endcase
  endfunction

  // Transaction model: one grant per three cycles, round-robin (or fixed) ties
  initial begin
    int          busy_cnt;
    bit          last_gnt;
    int          w;
    logic [32:0] r;
    busy_cnt = 0;
    last_gnt = 1'b1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sb.delete();
        busy_cnt = 0;
        last_gnt = 1'b1;
      end else begin
        cyc++;
        if (busy_cnt > 0) begin
          busy_cnt--;
        end else if (req[0] || req[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          w = req[0] ? 0 : 1;
`else
          if (req[0] && req[1]) w = last_gnt ? 0 : 1;
          else                  w = req[1] ? 1 : 0;
`endif
          last_gnt = w[0];
          r = ref_alu(opt[w], opr1[w], opr2[w], sa[w]);
          sb.push_back('{port: w, due: cyc + 1, res: r[31:0], ill: r[32]});
          busy_cnt = 2;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          fail("ack missing", $sformatf("no ack, expected port %0d at cycle %0d",
                                        sb[0].port, sb[0].due));
          void'(sb.pop_front());
        end
        if (ack0 || ack1) begin
          if (ack0 && ack1) begin
            fail("ack onehot", "got ack0=1 ack1=1, expected at most one");
          end else if (sb.size() == 0) begin
            fail("unexpected ack", $sformatf("got ack0=%0b ack1=%0b, expected none", ack0, ack1));
          end else begin
            e = sb.pop_front();
            check("ack port", ack1 ? 32'd1 : 32'd0, 32'(e.port));
            check("ack cycle", 32'(cyc), 32'(e.due));
            check("result", result, e.res);
            check("illegal", {31'b0, illegal}, {31'b0, e.ill});
          end
        end
      end
    end
  end

  // Caller is 1 time unit past a rising edge; returns in the same phase
  task automatic do_op(input int p, input logic [OptW-1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] s, input bit hold);
    int n = 0;
    req[p]  = 1'b1;
    opt[p]  = o;
    opr1[p] = a;
    opr2[p] = b;
    sa[p]   = s;
    while (1) begin
      @(negedge clk);
      if ((p == 0 ? ack0 : ack1) === 1'b1) break;
      n++;
      if (n >= Timeout) begin
        fail($sformatf("port%0d ack timeout", p), "got no ack, expected one");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      bit hold = ($urandom_range(0, 1) == 1) && (i < n - 1);
      do_op(p, OptW'($urandom_range(0, 15)), $urandom, $urandom, $urandom, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ack0"}, {31'b0, ack0}, 32'd0);
    check({tag, " ack1"}, {31'b0, ack1}, 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " illegal"}, {31'b0, illegal}, 32'd0);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; opr1[i] = '0; opr2[i] = '0; sa[i] = '0; opt[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // First tie after reset goes to port 0
    fork
      do_op(0, OptSubu, 32'd10, 32'd3, 32'd0, 1'b0);
      do_op(1, OptOr, 32'hF0, 32'h0F, 32'd0, 1'b0);
    join

    do_op(0, OptAddu, 32'd5, 32'd7, 32'd0, 1'b0);

    // Both ports holding req back-to-back
    fork
      for (int i = 0; i < 3; i++) do_op(0, OptAddu, 32'(i), 32'd100, 32'd0, i < 2);
      for (int i = 0; i < 3; i++) do_op(1, OptXor, 32'(i), 32'hFF00, 32'd0, i < 2);
    join

    do_op(1, OptW'(15), 32'd1, 32'd2, 32'd3, 1'b0);
    do_op(1, OptSltu, 32'd1, 32'd2, 32'd0, 1'b0);

    // Reset while an operation is in EXEC
    req[0] = 1'b1; opt[0] = OptAddu; opr1[0] = 32'd9; opr2[0] = 32'd9;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid-op reset");
    req[0] = 1'b0;
    #2 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    fork
      do_op(0, OptSllImm, 32'd0, 32'd1, 32'd4, 1'b0);
      do_op(1, OptSubu, 32'd1, 32'd2, 32'd0, 1'b0);
    join

    fork
      rand_port(0, 15);
      rand_port(1, 15);
    join

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
